// File: rtl/program_loader.sv
// Streams a program image into instruction memory, holding the processor
// in start-up until the image is written and the hold window has elapsed.
module program_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h00400020,
    parameter int          MAX_WORDS   = 1024,
    parameter int          HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        start_up,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_start_up,
    output logic        done,
    output logic [10:0] word_count,
    output logic        error
);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

    localparam logic [10:0] LAST_IDX = 11'(MAX_WORDS - 1);
    localparam logic [15:0] HOLD_LIM = 16'(HOLD_CYCLES);

    state_t      state, state_nx;
    logic        we_q;
    logic [15:0] hold_cnt;
    logic        loading;
    logic        accept;
    logic        at_cap;
    logic        overflow;

    assign loading  = (state == IDLE) || (state == LOAD);
    assign in_ready = loading && !start_up;
    assign accept   = in_valid && in_ready;
    assign at_cap   = (word_count == LAST_IDX);
    assign overflow = at_cap && !in_last;

    // A write registered on the edge that start_up arrives behind is
    // suppressed so an abandoned load never reaches memory.
    assign imem_we      = we_q && !start_up;
    assign cpu_start_up = (state != RUN);
    assign done         = (state == RUN);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, LOAD: begin
                if (accept) begin
                    if (in_last || at_cap) state_nx = HOLD;
                    else                   state_nx = LOAD;
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_LIM) state_nx = RUN;
            end
            RUN: state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (start_up) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'h0;
            word_count <= 11'd0;
            error      <= 1'b0;
            hold_cnt   <= 16'd0;
        end else begin
            state <= state_nx;
            we_q  <= accept;
            if (accept) begin
                imem_addr  <= BASE_ADDR + {19'd0, word_count, 2'b00};
                imem_wdata <= in_data;
                word_count <= word_count + 11'd1;
                if (overflow) error <= 1'b1;
            end
            // The count starts with the final write cycle, so the hold
            // window covers HOLD_CYCLES full cycles after it.
            if (state == HOLD && hold_cnt != HOLD_LIM)
                hold_cnt <= hold_cnt + 16'd1;
            else if (state != HOLD)
                hold_cnt <= 16'd0;
        end
    end

endmodule
